// File: rtl/fetch_queue_unit.sv
// Fetch stage: single-outstanding imem reads, BTB redirect at response, DEPTH-entry queue to decode.
// Entry visible one cycle after imem_resp; stops issuing reads (HOLD) while the queue is full.
module fetch_queue_unit #(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           new_pc,
  output logic                       imem_read,
  output logic [WIDTH-1:0]           imem_address,
  input  logic [WIDTH-1:0]           imem_rdata,
  input  logic                       imem_resp,
  input  logic                       hit,
  input  logic                       predict_in,
  input  logic [WIDTH-1:0]           bta_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_instr,
  output logic [WIDTH-1:0]           out_pc,
  output logic                       out_hit,
  output logic                       out_predict,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc;
    logic             hit;
    logic             predict;
  } entry_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc, pc_nxt;
  logic [WIDTH-1:0] redirect, redirect_nxt;
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count_q, count_post;
  entry_t           fifo_mem [DEPTH];
  logic             push, pop;

  assign imem_read    = rst_n && (state != HOLD);
  assign imem_address = pc;
  assign out_valid    = rst_n && (count_q != '0);
  assign count        = count_q;

  assign out_instr    = fifo_mem[rd_ptr].instr;
  assign out_pc       = fifo_mem[rd_ptr].pc;
  assign out_hit      = fifo_mem[rd_ptr].hit;
  assign out_predict  = fifo_mem[rd_ptr].predict;

  // A flush cancels both the push and the pop of its cycle via the queue clear below.
  assign push       = (state == FETCH) && imem_resp && !flush;
  assign pop        = out_valid && out_ready;
  assign count_post = count_q + CW'(push) - CW'(pop);

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    redirect_nxt = redirect;
    case (state)
      FETCH: begin
        if (flush) begin
          if (imem_resp) begin
            pc_nxt = new_pc;
          end else begin
            redirect_nxt = new_pc;
            state_nxt    = DROP;
          end
        end else if (imem_resp) begin
          pc_nxt = (hit && predict_in) ? bta_in : pc + WIDTH'(2);
          if (count_post == CW'(DEPTH)) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (flush) begin
          pc_nxt    = new_pc;
          state_nxt = FETCH;
        end else if (pop) begin
          state_nxt = FETCH;
        end
      end
      DROP: begin
        // The read already issued must complete before the redirected fetch starts.
        if (imem_resp) begin
          pc_nxt    = flush ? new_pc : redirect;
          state_nxt = FETCH;
        end else if (flush) begin
          redirect_nxt = new_pc;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= PC_RESET;
      redirect <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      redirect <= redirect_nxt;
      if (flush) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count_q <= count_post;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{instr: imem_rdata, pc: pc, hit: hit, predict: predict_in};
  end

endmodule
